// File: rtl/id_rf_pipe.sv
// Decode/register-read stage: write-back mux, register bank with bypass,
// immediate extender and a single valid/ready output slot with stall refresh.
module id_rf_pipe #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NREG    = 8,
  parameter int unsigned CONST_W = 12,
  parameter bit          R0_ZERO = 1'b1,
  localparam int unsigned SEL_W  = $clog2(NREG)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic [SEL_W-1:0]   sel_a,
  input  logic [SEL_W-1:0]   sel_b,
  input  logic [2:0]         ex_ctrl,
  input  logic [CONST_W-1:0] constant,
  input  logic               wb_en,
  input  logic               wb_sel,
  input  logic [SEL_W-1:0]   wb_dest,
  input  logic [DATA_W-1:0]  wb_alu,
  input  logic [DATA_W-1:0]  wb_mem,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  A,
  output logic [DATA_W-1:0]  B,
  output logic [DATA_W-1:0]  const_ext,
  output logic [SEL_W-1:0]   out_dest
);

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] ce_q, ce_d;
  logic [SEL_W-1:0]  dest_q, dest_d;
  logic [SEL_W-1:0]  selb_q, selb_d;

  logic [DATA_W-1:0] wbd;
  logic              wb_we;
  logic [DATA_W-1:0] rd_a, rd_b, ext;
  logic [7:0]        const8;
  logic              load;

  // Write-back data select and effective write enable (register 0 may be hardwired)
  always_comb begin
    wbd   = wb_sel ? wb_mem : wb_alu;
    wb_we = wb_en && !(R0_ZERO && (wb_dest == '0));
  end

  // Register bank next state
  always_comb begin
    rf_d = rf_q;
    if (wb_we) rf_d[wb_dest] = wbd;
  end

  // Source reads with same-cycle write-back bypass
  always_comb begin
    if (R0_ZERO && (sel_a == '0))            rd_a = '0;
    else if (wb_en && (wb_dest == sel_a))    rd_a = wbd;
    else                                     rd_a = rf_q[sel_a];
    if (R0_ZERO && (sel_b == '0))            rd_b = '0;
    else if (wb_en && (wb_dest == sel_b))    rd_b = wbd;
    else                                     rd_b = rf_q[sel_b];
  end

  // Immediate extender
  always_comb begin
    const8 = constant[7:0];
    case (ex_ctrl)
      3'd0:    ext = DATA_W'(constant);
      3'd1:    ext = DATA_W'($signed(constant));
      3'd2:    ext = DATA_W'(const8);
      3'd3:    ext = DATA_W'($signed(const8));
      3'd4:    ext = {const8, {(DATA_W-8){1'b0}}};
      default: ext = '0;
    endcase
  end

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // Slot next state: flush, load, drain, or stall with operand refresh
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    ce_d    = ce_q;
    dest_d  = dest_q;
    selb_d  = selb_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      a_d     = rd_a;
      b_d     = rd_b;
      ce_d    = ext;
      dest_d  = sel_a;
      selb_d  = sel_b;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      if (wb_we && (wb_dest == dest_q)) a_d = wbd;
      if (wb_we && (wb_dest == selb_q)) b_d = wbd;
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_q    <= '{default: '0};
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ce_q    <= '0;
      dest_q  <= '0;
      selb_q  <= '0;
    end else begin
      rf_q    <= rf_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ce_q    <= ce_d;
      dest_q  <= dest_d;
      selb_q  <= selb_d;
    end
  end

  assign out_valid = valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign const_ext = ce_q;
  assign out_dest  = dest_q;

endmodule

// File: tb/tb_id_rf_pipe.sv
// Directed bench for id_rf_pipe: vector table plus stall/flush/reset sequences.
module tb_id_rf_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush;
  logic [2:0]  sel_a, sel_b, ex_ctrl;
  logic [11:0] constant;
  logic        wb_en, wb_sel;
  logic [2:0]  wb_dest;
  logic [15:0] wb_alu, wb_mem;
  logic        out_valid, out_ready;
  logic [15:0] A, B, const_ext;
  logic [2:0]  out_dest;

  int checks = 0;
  int errors = 0;

  id_rf_pipe dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .sel_a(sel_a), .sel_b(sel_b), .ex_ctrl(ex_ctrl),
    .constant(constant), .wb_en(wb_en), .wb_sel(wb_sel), .wb_dest(wb_dest),
    .wb_alu(wb_alu), .wb_mem(wb_mem), .out_valid(out_valid),
    .out_ready(out_ready), .A(A), .B(B), .const_ext(const_ext),
    .out_dest(out_dest)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  sa, sb, ex;
    logic [11:0] c;
    logic        we, ws;
    logic [2:0]  wd;
    logic [15:0] alu, mem;
    logic [15:0] ea, eb, ec;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; sel_a = 0; sel_b = 0; ex_ctrl = 0; constant = 0;
    wb_en = 0; wb_sel = 0; wb_dest = 0; wb_alu = 0; wb_mem = 0; out_ready = 1;
  endtask

  initial begin
    //        sa  sb  ex  c       we ws wd  alu      mem      ea       eb       ec
    vecs[0] = '{3'd5, 3'd3, 3'd0, 12'h9A5, 1, 1, 3'd5, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h1234, 16'h09A5};
    vecs[1] = '{3'd1, 3'd5, 3'd1, 12'h9A5, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'hF9A5};
    vecs[2] = '{3'd3, 3'd3, 3'd2, 12'h9A5, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 16'h00A5};
    vecs[3] = '{3'd0, 3'd5, 3'd3, 12'h9A5, 1, 0, 3'd0, 16'hFFFF, 16'h0000, 16'h0000, 16'hBEEF, 16'hFFA5};
    vecs[4] = '{3'd7, 3'd0, 3'd4, 12'h9A5, 1, 0, 3'd7, 16'h0ABC, 16'h0000, 16'h0ABC, 16'h0000, 16'hA500};
    vecs[5] = '{3'd6, 3'd7, 3'd6, 12'h9A5, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0ABC, 16'h0000};
    vecs[6] = '{3'd2, 3'd6, 3'd5, 12'h7FF, 1, 0, 3'd2, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0000};
    vecs[7] = '{3'd4, 3'd2, 3'd1, 12'h7FF, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h07FF};

    idle();
    reset = 1;
    #12;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_A", 32'(A), 32'h0);
    chk("rst_B", 32'(B), 32'h0);
    chk("rst_const", 32'(const_ext), 32'h0);
    chk("rst_dest", 32'(out_dest), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clock);
    reset = 0;

    // reg3 = 0x1234 via ALU path
    wb_en = 1; wb_sel = 0; wb_dest = 3; wb_alu = 16'h1234;
    step();
    chk("wr_no_valid", 32'(out_valid), 32'h0);
    wb_en = 0;
    in_valid = 1; sel_a = 3; sel_b = 0; ex_ctrl = 0; constant = 12'h9A5;
    step();
    chk("first_valid", 32'(out_valid), 32'h1);
    chk("first_A", 32'(A), 32'h1234);
    chk("first_B", 32'(B), 32'h0);
    chk("first_dest", 32'(out_dest), 32'h3);

    // table: back-to-back loads with out_ready=1
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; out_ready = 1;
      sel_a = vecs[i].sa; sel_b = vecs[i].sb; ex_ctrl = vecs[i].ex; constant = vecs[i].c;
      wb_en = vecs[i].we; wb_sel = vecs[i].ws; wb_dest = vecs[i].wd;
      wb_alu = vecs[i].alu; wb_mem = vecs[i].mem;
      step();
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'h1);
      chk($sformatf("v%0d_A", i), 32'(A), 32'(vecs[i].ea));
      chk($sformatf("v%0d_B", i), 32'(B), 32'(vecs[i].eb));
      chk($sformatf("v%0d_const", i), 32'(const_ext), 32'(vecs[i].ec));
      chk($sformatf("v%0d_dest", i), 32'(out_dest), 32'(vecs[i].sa));
    end

    // stall refresh: load reg2 (0x0001) while draining, then stall
    idle();
    in_valid = 1; sel_a = 2; sel_b = 2; ex_ctrl = 0; constant = 12'h005; out_ready = 1;
    step();
    chk("stl_load_A", 32'(A), 32'h0001);
    out_ready = 0; sel_a = 6; sel_b = 6; constant = 12'h0FF;
    wb_en = 1; wb_sel = 0; wb_dest = 2; wb_alu = 16'h7777;
    #1;
    chk("stl_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("stl_valid", 32'(out_valid), 32'h1);
    chk("stl_A", 32'(A), 32'h7777);
    chk("stl_B", 32'(B), 32'h7777);
    chk("stl_dest", 32'(out_dest), 32'h2);
    chk("stl_const", 32'(const_ext), 32'h0005);
    wb_dest = 6; wb_alu = 16'h0066;
    step();
    chk("stl_other_A", 32'(A), 32'h7777);
    chk("stl_other_B", 32'(B), 32'h7777);

    // flush while stalled with input present and concurrent write-back
    flush = 1; in_valid = 1; sel_a = 5; sel_b = 5;
    wb_en = 1; wb_dest = 4; wb_alu = 16'h0042;
    step();
    chk("fl_valid", 32'(out_valid), 32'h0);
    chk("fl_dest", 32'(out_dest), 32'h2);
    flush = 0; wb_en = 0; in_valid = 1; sel_a = 4; sel_b = 2; out_ready = 1;
    step();
    chk("fl_wb_A", 32'(A), 32'h0042);
    chk("fl_wb_B", 32'(B), 32'h7777);

    // drain without new input
    in_valid = 0;
    step();
    chk("drain_valid", 32'(out_valid), 32'h0);

    // back-to-back sequence, no bubbles
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; out_ready = 1; sel_a = 3'(i); sel_b = 0;
      step();
      chk($sformatf("b2b%0d_valid", i), 32'(out_valid), 32'h1);
      chk($sformatf("b2b%0d_dest", i), 32'(out_dest), 32'(i));
    end

    // async reset mid-stream (mid-cycle)
    out_ready = 0;
    #2;
    reset = 1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_dest", 32'(out_dest), 32'h0);
    @(negedge clock);
    reset = 0;
    idle();
    in_valid = 1; sel_a = 3; sel_b = 5;
    step();
    chk("arst_bank_A", 32'(A), 32'h0);
    chk("arst_bank_B", 32'(B), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_rf_pipe.md
Name: id_rf_pipe

Overview:
- Parametrised decode/register-read stage with a registered output slot. It sits between instruction decode and execute.
- Contains a write-back result mux (ALU/memory), an NREG x DATA_W register bank with same-cycle write-back bypass, and a multi-mode constant extender.
- Output is a single pipeline register with a valid/ready handshake, stall and flush.
- A stalled slot keeps its operands current with write-backs that land while it waits.

Parameters:
- DATA_W, 16, register/operand width (>= 9)
- NREG, 8, number of registers (power of 2, >= 2); SEL_W = $clog2(NREG)
- CONST_W, 12, immediate field width (8 <= CONST_W <= DATA_W)
- R0_ZERO, 1, 1: register 0 reads as 0 and ignores writes

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept; = !out_valid || out_ready (combinational)
- flush  in  1  kill slot contents and ignore this cycle's input
- sel_a  in  SEL_W  source A; also the destination (two-address format)
- sel_b  in  SEL_W  source B
- ex_ctrl  in  3  extender mode
- constant  in  CONST_W  raw immediate
- wb_en  in  1  write-back enable
- wb_sel  in  1  0: wb_alu, 1: wb_mem
- wb_dest  in  SEL_W  write-back register
- wb_alu  in  DATA_W  ALU result
- wb_mem  in  DATA_W  memory data
- out_valid  out  1  slot holds a valid instruction
- out_ready  in  1  execute accepts the slot
- A  out  DATA_W  operand A
- B  out  DATA_W  operand B
- const_ext  out  DATA_W  extended immediate
- out_dest  out  SEL_W  destination (captured sel_a)

Behaviour:
- Reset (async): all registers, A, B, const_ext and out_dest go to 0; out_valid goes to 0.
- Write-back data: wbd = wb_sel ? wb_mem : wb_alu.
- Write-back write: on posedge, reg[wb_dest] <= wbd when wb_en, except when R0_ZERO and wb_dest == 0.
- Read path: rd(s) = 0 if R0_ZERO && s == 0; otherwise wbd if wb_en && wb_dest == s (bypass); otherwise reg[s].
- Extender modes, by ex_ctrl:
  - 0: zero-extend constant
  - 1: sign-extend constant
  - 2: zero-extend constant[7:0]
  - 3: sign-extend constant[7:0]
  - 4: constant[7:0] << (DATA_W-8), low bits 0
  - 5-7: 0
- Load: load = in_valid && in_ready && !flush. On load, the slot captures rd(sel_a), rd(sel_b), the extender output and sel_a, and sets out_valid = 1. The internal sel_b copy is also kept. Latency is 1 cycle.
- Drain: if out_valid && out_ready && !load, out_valid <= 0 and the data is held (don't-care).
- Flush: out_valid <= 0 next cycle and no capture, regardless of in_valid or out_ready. A write-back in the same cycle still commits to the bank.
- Stall refresh: while out_valid && !out_ready && !flush, a write-back to a held source register updates the slot.
  - If wb_en and wb_dest == held sel_a (honouring R0_ZERO), A <= wbd.
  - The same rule applies independently for B against the held sel_b.
- Simultaneous load and drain: the new instruction replaces the old; out_valid stays 1.
- Reset mid-stall: the slot clears immediately; the bank clears.

Test Plan:
- Reset, then write reg3 = 0x1234 via wb_alu; next cycle issue sel_a=3, sel_b=0 -> A=0x1234, B=0x0000 (R0_ZERO), out_valid=1 one cycle after load.
- Bypass: same cycle issue sel_a=5 with wb_en, wb_dest=5, wb_sel=1, wb_mem=0xBEEF -> A=0xBEEF; reg5 then reads 0xBEEF.
- Extender, constant=0x9A5:
  - mode 0 -> 0x09A5
  - mode 1 -> 0xF9A5
  - mode 2 -> 0x00A5
  - mode 3 -> 0xFFA5
  - mode 4 -> 0xA500
  - mode 6 -> 0x0000
- Stall refresh: load sel_a=2 (0x0001), out_ready=0; next cycle wb reg2 = 0x7777 -> A=0x7777 while stalled, out_valid held, in_ready=0 and new input ignored.
- Flush while stalled with in_valid=1 -> out_valid=0 next cycle, no capture; a concurrent wb to reg4 = 0x0042 persists.
- Back-to-back: in_valid=1 and out_ready=1 for 4 cycles with sel_a=1..4 -> out_dest sequence 1,2,3,4 with no bubbles; assert reset mid-stream -> out_valid=0 asynchronously.
